// File: rtl/regfile_bank_if.sv
// Register-file access bundle: one write port, two read ports, debug map.
// Driver side is the master; the register bank is the slave.
interface regfile_bank_if;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic [4:0]  ctrl_readRegA;
  logic [4:0]  ctrl_readRegB;
  logic [31:0] data_readRegA;
  logic [31:0] data_readRegB;
  logic [31:0] written_map;

  modport master (
    output ctrl_writeEnable,
    output ctrl_writeReg,
    output data_writeReg,
    output ctrl_readRegA,
    output ctrl_readRegB,
    input  data_readRegA,
    input  data_readRegB,
    input  written_map
  );

  modport slave (
    input  ctrl_writeEnable,
    input  ctrl_writeReg,
    input  data_writeReg,
    input  ctrl_readRegA,
    input  ctrl_readRegB,
    output data_readRegA,
    output data_readRegB,
    output written_map
  );
endinterface

// File: rtl/regfile_bank.sv
// cp4 architectural register file: 32x32, 1W/2R, r0 hardwired to zero,
// optional write-to-read bypass and a written-since-reset bitmap.
module mux_32 #(
  parameter int W = 32
) (
  input  logic [W-1:0] in_i [32],
  input  logic [4:0]   sel_i,
  output logic [W-1:0] out_o
);
  assign out_o = in_i[sel_i];
endmodule

module regfile_bank #(
  parameter int WIDTH  = 32,
  parameter int BYPASS = 1
) (
  input logic           clock,
  input logic           ctrl_reset,
  regfile_bank_if.slave bus
);
  if (WIDTH != 32) begin : g_bad_width
    $error("regfile_bank: WIDTH must be 32");
  end

  localparam bit BYP = (BYPASS != 0);

  logic [WIDTH-1:0] regs_q [1:31];
  logic [WIDTH-1:0] regs_d [1:31];
  logic [31:1]      written_q;
  logic [31:1]      written_d;
  logic [31:0]      we_dec;
  logic [WIDTH-1:0] mux_in [32];
  logic [WIDTH-1:0] mux_a;
  logic [WIDTH-1:0] mux_b;
  logic             wr_live;
  logic             byp_a;
  logic             byp_b;

  always_comb begin
    we_dec = '0;
    if (bus.ctrl_writeEnable) begin
      we_dec[bus.ctrl_writeReg] = 1'b1;
    end
    we_dec[0] = 1'b0;
  end

  always_comb begin
    regs_d    = regs_q;
    written_d = written_q;
    for (int i = 1; i < 32; i++) begin
      if (we_dec[i]) begin
        regs_d[i]    = bus.data_writeReg;
        written_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= '0;
      end
      written_q <= '0;
    end else begin
      regs_q    <= regs_d;
      written_q <= written_d;
    end
  end

  // r0 feeds the mux as a constant, never a flop
  always_comb begin
    mux_in[0] = '0;
    for (int i = 1; i < 32; i++) begin
      mux_in[i] = regs_q[i];
    end
  end

  mux_32 #(.W(WIDTH)) u_mux_a (
    .in_i  (mux_in),
    .sel_i (bus.ctrl_readRegA),
    .out_o (mux_a)
  );

  mux_32 #(.W(WIDTH)) u_mux_b (
    .in_i  (mux_in),
    .sel_i (bus.ctrl_readRegB),
    .out_o (mux_b)
  );

  // reset gates the bypass so reads are 0 while held
  assign wr_live = BYP && ctrl_reset && bus.ctrl_writeEnable
                   && (bus.ctrl_writeReg != 5'd0);
  assign byp_a = wr_live && (bus.ctrl_readRegA == bus.ctrl_writeReg);
  assign byp_b = wr_live && (bus.ctrl_readRegB == bus.ctrl_writeReg);

  assign bus.data_readRegA = byp_a ? bus.data_writeReg : mux_a;
  assign bus.data_readRegB = byp_b ? bus.data_writeReg : mux_b;
  assign bus.written_map   = {written_q, 1'b0};
endmodule

// File: tb/tb_regfile_bank.sv
// Bench for regfile_bank: directed table, fill/sweep, mid-cycle reset,
// then random traffic against an array model (BYPASS=1 and BYPASS=0).
module tb_regfile_bank;
  logic clock = 1'b0;
  logic ctrl_reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clock = ~clock;

  regfile_bank_if b1 ();
  regfile_bank_if b0 ();

  assign b0.ctrl_writeEnable = b1.ctrl_writeEnable;
  assign b0.ctrl_writeReg    = b1.ctrl_writeReg;
  assign b0.data_writeReg    = b1.data_writeReg;
  assign b0.ctrl_readRegA    = b1.ctrl_readRegA;
  assign b0.ctrl_readRegB    = b1.ctrl_readRegB;

  regfile_bank #(.WIDTH(32), .BYPASS(1)) u_dut1 (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .bus        (b1)
  );

  regfile_bank #(.WIDTH(32), .BYPASS(0)) u_dut0 (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .bus        (b0)
  );

  typedef struct {
    logic        we;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] ea;
    logic [31:0] eb;
    logic [31:0] ea0;
    logic [31:0] eb0;
    logic [31:0] em;
  } vec_t;

  vec_t        tbl [7];
  logic [31:0] mdl [32];
  logic [31:0] mmap;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(logic we, logic [4:0] wr, logic [31:0] wd,
                       logic [4:0] ra, logic [4:0] rb);
    b1.ctrl_writeEnable = we;
    b1.ctrl_writeReg    = wr;
    b1.data_writeReg    = wd;
    b1.ctrl_readRegA    = ra;
    b1.ctrl_readRegB    = rb;
  endtask

  function automatic logic [31:0] exp_rd(bit byp, logic [4:0] ra);
    if (!ctrl_reset) return 32'h0;
    if (byp && b1.ctrl_writeEnable && b1.ctrl_writeReg != 0
        && ra == b1.ctrl_writeReg) return b1.data_writeReg;
    return mdl[ra];
  endfunction

  task automatic chk_model(string tag);
    chk({tag, ".A1"}, b1.data_readRegA, exp_rd(1, b1.ctrl_readRegA));
    chk({tag, ".B1"}, b1.data_readRegB, exp_rd(1, b1.ctrl_readRegB));
    chk({tag, ".A0"}, b0.data_readRegA, exp_rd(0, b1.ctrl_readRegA));
    chk({tag, ".B0"}, b0.data_readRegB, exp_rd(0, b1.ctrl_readRegB));
    chk({tag, ".map1"}, b1.written_map, mmap);
    chk({tag, ".map0"}, b0.written_map, mmap);
  endtask

  task automatic edge_update();
    @(posedge clock);
    if (ctrl_reset && b1.ctrl_writeEnable && b1.ctrl_writeReg != 0) begin
      mdl[b1.ctrl_writeReg] = b1.data_writeReg;
      mmap[b1.ctrl_writeReg] = 1'b1;
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    mmap = 32'h0;
  endtask

  initial begin
    tbl[0] = '{1, 5,  32'hDEADBEEF, 5,  5,
               32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 32'h0};
    tbl[1] = '{0, 0,  32'h0,        5,  5,
               32'hDEADBEEF, 32'hDEADBEEF,
               32'hDEADBEEF, 32'hDEADBEEF, 32'h20};
    tbl[2] = '{1, 0,  32'hFFFFFFFF, 0,  5,
               0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 32'h20};
    tbl[3] = '{0, 0,  32'h0,        0,  0,  0, 0, 0, 0, 32'h20};
    tbl[4] = '{1, 31, 32'h1,        0,  31, 0, 32'h1, 0, 0, 32'h20};
    tbl[5] = '{1, 31, 32'h12345678, 31, 30,
               32'h12345678, 0, 32'h1, 0, 32'h80000020};
    tbl[6] = '{0, 0,  32'h0,        31, 5,
               32'h12345678, 32'hDEADBEEF,
               32'h12345678, 32'hDEADBEEF, 32'h80000020};

    model_clear();
    ctrl_reset = 1'b0;
    drive(1, 9, 32'h55AA55AA, 9, 9);
    @(negedge clock);
    #1;
    chk("rst.byp_off.A", b1.data_readRegA, 32'h0);
    chk("rst.byp_off.B", b1.data_readRegB, 32'h0);
    @(negedge clock);
    ctrl_reset = 1'b1;
    for (int i = 0; i < 32; i++) begin
      drive(0, 0, 0, 5'(i), 5'(31 - i));
      #1;
      chk("rst.A", b1.data_readRegA, 32'h0);
      chk("rst.B", b1.data_readRegB, 32'h0);
    end
    chk("rst.map", b1.written_map, 32'h0);

    for (int i = 0; i < 7; i++) begin
      @(negedge clock);
      drive(tbl[i].we, tbl[i].wr, tbl[i].wd, tbl[i].ra, tbl[i].rb);
      #1;
      chk($sformatf("tbl%0d.A1", i), b1.data_readRegA, tbl[i].ea);
      chk($sformatf("tbl%0d.B1", i), b1.data_readRegB, tbl[i].eb);
      chk($sformatf("tbl%0d.A0", i), b0.data_readRegA, tbl[i].ea0);
      chk($sformatf("tbl%0d.B0", i), b0.data_readRegB, tbl[i].eb0);
      chk($sformatf("tbl%0d.map", i), b1.written_map, tbl[i].em);
      edge_update();
    end

    for (int i = 1; i < 32; i++) begin
      @(negedge clock);
      drive(1, 5'(i), 32'(i) * 32'h01010101, 0, 0);
      edge_update();
    end
    @(negedge clock);
    for (int i = 0; i < 32; i++) begin
      drive(0, 0, 0, 5'(i), 5'(31 - i));
      #1;
      chk($sformatf("sweep.A%0d", i), b1.data_readRegA,
          32'(i) * 32'h01010101);
      chk($sformatf("sweep.B%0d", i), b0.data_readRegB,
          32'(31 - i) * 32'h01010101);
    end
    chk("sweep.map", b1.written_map, 32'hFFFFFFFE);

    @(negedge clock);
    drive(1, 7, 32'hAAAA5555, 7, 7);
    #1;
    chk("mrst.pre.A1", b1.data_readRegA, 32'hAAAA5555);
    chk("mrst.pre.A0", b0.data_readRegA, 32'h07070707);
    #1;
    ctrl_reset = 1'b0;
    #1;
    chk("mrst.A1", b1.data_readRegA, 32'h0);
    chk("mrst.B1", b1.data_readRegB, 32'h0);
    chk("mrst.A0", b0.data_readRegA, 32'h0);
    chk("mrst.map", b1.written_map, 32'h0);
    model_clear();
    @(posedge clock);
    #1;
    chk("mrst.edge.A1", b1.data_readRegA, 32'h0);
    @(negedge clock);
    ctrl_reset = 1'b1;
    drive(0, 0, 0, 7, 7);
    @(negedge clock);
    #1;
    chk("mrst.post.A1", b1.data_readRegA, 32'h0);
    chk("mrst.post.B0", b0.data_readRegB, 32'h0);
    chk("mrst.post.map", b0.written_map, 32'h0);

    for (int n = 0; n < 400; n++) begin
      logic [4:0] wr;
      logic [4:0] ra;
      logic [4:0] rb;
      @(negedge clock);
      wr = 5'($urandom);
      ra = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom);
      drive(1'($urandom_range(0, 1)), wr, $urandom, ra, rb);
      #1;
      chk_model($sformatf("rnd%0d", n));
      edge_update();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
